// File: rtl/pipe_pkg.sv
// Shared types for the skid-buffered pipeline register: state encoding and default width.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } skid_state_e;

  localparam int PIPE_WIDTH_DEF = 32;

endpackage

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline stage with a main slot and a skid slot; in_ready is decoded from registered state only.
// Optional stall counter output enabled by defining PIPE_SKID_STALL_CNT_EN.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  skid_state_e state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic in_fire, out_fire;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL);
  assign out_data  = main_q;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = in_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          skid_d  = in_data;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so the only event is the head leaving.
        if (out_fire) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Data slots may still load on a flush cycle; their contents are don't-care once EMPTY.
    if (flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_SKID_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      stall_cnt_d = '0;
    end else if (out_valid && !out_ready) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
